// File: rtl/crossbar_slave_port.sv
// Slave-side endpoint of the 2-master crossbar: round-robin arbitration between
// the two masters, request latching toward the slave, and ack/rdata return.
module crossbar_slave_port #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_granted,
  output logic          m1_granted,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic [DW-1:0] m_rdata,
  output logic          m_err,
  output logic          slave_req,
  output logic          slave_cmd,
  output logic [AW-1:0] slave_addr,
  output logic [DW-1:0] slave_wdata,
  input  logic          slave_ack,
  input  logic [DW-1:0] slave_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          g0_d, g1_d, a0_d, a1_d, err_d, sreq_d, cmd_d, win1;
  logic [DW-1:0] rdata_d, wdata_d;
  logic [AW-1:0] addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b1;
      cnt_q       <= '0;
      m0_granted  <= 1'b0;
      m1_granted  <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m_rdata     <= '0;
      m_err       <= 1'b0;
      slave_req   <= 1'b0;
      slave_cmd   <= 1'b0;
      slave_addr  <= '0;
      slave_wdata <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      m0_granted  <= g0_d;
      m1_granted  <= g1_d;
      m0_ack      <= a0_d;
      m1_ack      <= a1_d;
      m_rdata     <= rdata_d;
      m_err       <= err_d;
      slave_req   <= sreq_d;
      slave_cmd   <= cmd_d;
      slave_addr  <= addr_d;
      slave_wdata <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    g0_d    = m0_granted;
    g1_d    = m1_granted;
    a0_d    = 1'b0;
    a1_d    = 1'b0;
    rdata_d = m_rdata;
    err_d   = m_err;
    sreq_d  = slave_req;
    cmd_d   = slave_cmd;
    addr_d  = slave_addr;
    wdata_d = slave_wdata;
    win1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that did not win last time takes the slave
          win1    = m1_req && (!m0_req || !rr_q);
          cmd_d   = win1 ? m1_cmd   : m0_cmd;
          addr_d  = win1 ? m1_addr  : m0_addr;
          wdata_d = win1 ? m1_wdata : m0_wdata;
          g0_d    = !win1;
          g1_d    = win1;
          sreq_d  = 1'b1;
          rr_d    = win1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // A slave ack in the final timeout cycle still completes normally
        if (slave_ack) begin
          rdata_d = slave_rdata;
          err_d   = 1'b0;
          sreq_d  = 1'b0;
          a0_d    = m0_granted;
          a1_d    = m1_granted;
          state_d = RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          sreq_d  = 1'b0;
          a0_d    = m0_granted;
          a1_d    = m1_granted;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        g0_d    = 1'b0;
        g1_d    = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_crossbar_slave_port.sv
// Randomized self-checking bench for crossbar_slave_port against a
// transaction-level model of arbitration, latching, timeout and response.
module tb_crossbar_slave_port;

  localparam int AW = 32, DW = 32, TIMEOUT = 16, CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_cmd, m1_req, m1_cmd;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_granted, m1_granted, m0_ack, m1_ack, m_err;
  logic [DW-1:0] m_rdata;
  logic          slave_req, slave_cmd, slave_ack;
  logic [AW-1:0] slave_addr;
  logic [DW-1:0] slave_wdata, slave_rdata;

  int errors = 0;
  int checks = 0;
  bit last_winner = 1'b1;  // after reset master 0 wins the first tie

  crossbar_slave_port #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_granted(m0_granted), .m1_granted(m1_granted),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m_rdata(m_rdata), .m_err(m_err),
    .slave_req(slave_req), .slave_cmd(slave_cmd), .slave_addr(slave_addr),
    .slave_wdata(slave_wdata), .slave_ack(slave_ack), .slave_rdata(slave_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("excl_grant", 64'(m0_granted & m1_granted), 64'd0);
      check("excl_ack", 64'(m0_ack & m1_ack), 64'd0);
    end
  end

  task automatic set_reqs(input bit r0, input bit r1);
    m0_req = r0; m0_cmd = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
    m1_req = r1; m1_cmd = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"}, {m0_granted, m1_granted, m0_ack, m1_ack, m_err, slave_req, slave_cmd},
          64'd0);
    check({tag, "_data"}, {m_rdata, slave_addr}, 64'd0);
    check({tag, "_wdata"}, 64'(slave_wdata), 64'd0);
  endtask

  // One full transaction starting from an IDLE negedge with requests already set.
  // ack_at: 1-based slave_req cycle in which the slave acks; 0 = never.
  task automatic txn(input int ack_at, input logic [DW-1:0] rd, input bit drop);
    bit            w, exp_err, stable, quiet;
    logic          e_cmd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int            n, exp_n;
    if (m0_req && !m1_req)      w = 1'b0;
    else if (m1_req && !m0_req) w = 1'b1;
    else                        w = !last_winner;
    e_cmd   = w ? m1_cmd   : m0_cmd;
    e_addr  = w ? m1_addr  : m0_addr;
    e_wdata = w ? m1_wdata : m0_wdata;
    exp_err = (ack_at < 1) || (ack_at > TIMEOUT);
    exp_n   = exp_err ? TIMEOUT : ack_at;
    tick();
    check("grant_req", 64'(slave_req), 64'd1);
    check("grant_who", {m0_granted, m1_granted}, {62'd0, !w, w});
    check("latch_cmd", 64'(slave_cmd), 64'(e_cmd));
    check("latch_addr", 64'(slave_addr), 64'(e_addr));
    check("latch_wdata", 64'(slave_wdata), 64'(e_wdata));
    if (drop) begin
      if (w) begin m1_req = 1'b0; m1_addr = ~m1_addr; m1_wdata = $urandom; end
      else   begin m0_req = 1'b0; m0_addr = ~m0_addr; m0_wdata = $urandom; end
    end
    n = 0; stable = 1'b1; quiet = 1'b1;
    while (slave_req === 1'b1 && n < 100) begin
      n++;
      if (slave_cmd !== e_cmd || slave_addr !== e_addr || slave_wdata !== e_wdata ||
          m0_granted !== !w || m1_granted !== w) stable = 1'b0;
      if (m0_ack || m1_ack) quiet = 1'b0;
      slave_ack   = (n == ack_at);
      slave_rdata = (n == ack_at) ? rd : $urandom;
      tick();
    end
    slave_ack = 1'b0;
    check("req_cycles", 64'(n), 64'(exp_n));
    check("req_stable", 64'(stable), 64'd1);
    check("req_no_ack", 64'(quiet), 64'd1);
    check("resp_ack", {m0_ack, m1_ack}, {62'd0, !w, w});
    check("resp_grant", {m0_granted, m1_granted}, {62'd0, !w, w});
    check("resp_err", 64'(m_err), 64'(exp_err));
    check("resp_rdata", 64'(m_rdata), exp_err ? 64'd0 : 64'(rd));
    last_winner = w;
    tick();
    check("idle_clear", {m0_ack, m1_ack, m0_granted, m1_granted, m_err}, 64'd0);
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; slave_ack = 1'b0; slave_rdata = '0;
    set_reqs(1'b0, 1'b0);
    tick();
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Stray slave ack while idle
    quiet = 1'b1;
    slave_ack = 1'b1; slave_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m0_ack || m1_ack || slave_req || m0_granted || m1_granted) quiet = 1'b0;
    end
    slave_ack = 1'b0;
    check("stray_ack", 64'(quiet), 64'd1);

    // Both masters held requesting: alternation from reset
    set_reqs(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) txn(1, $urandom, 1'b0);
    set_reqs(1'b0, 1'b0);
    tick();

    // Single read from master 0
    set_reqs(1'b1, 1'b0);
    m0_cmd = 1'b0; m0_addr = 32'h10;
    txn(3, 32'hDEADBEEF, 1'b1);

    // Master 1 write, fields change and req drops after grant
    set_reqs(1'b0, 1'b1);
    m1_cmd = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    txn(4, $urandom, 1'b1);

    // Timeout with no ack, then ack in the last permitted cycle
    set_reqs(1'b1, 1'b0);
    txn(0, $urandom, 1'b1);
    set_reqs(1'b1, 1'b0);
    txn(TIMEOUT, 32'hA5A5_5A5A, 1'b1);

    // Reset during REQ abandons the transaction
    set_reqs(1'b1, 1'b0);
    tick(); tick();
    check("pre_reset_req", 64'(slave_req), 64'd1);
    rst = 1'b1; m0_req = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst = 1'b0;
    last_winner = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m0_ack || m1_ack || slave_req) quiet = 1'b0;
    end
    check("post_reset_quiet", 64'(quiet), 64'd1);
    set_reqs(1'b0, 1'b1);
    txn(2, $urandom, 1'b1);
    set_reqs(1'b1, 1'b1);
    txn(1, $urandom, 1'b1);
    set_reqs(1'b0, 1'b0);
    tick();

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      int r, ack_at;
      r = $urandom_range(1, 3);
      set_reqs(r[0], r[1]);
      ack_at = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TIMEOUT + 3);
      txn(ack_at, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        set_reqs(1'b0, 1'b0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
